// File: rtl/pong_pkg.sv
// Shared constants, encodings and payload types for the pong ball logic.
package pong_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned CALC_W   = 11;
    localparam int unsigned RGB_W    = 12;

    typedef enum logic [1:0] {
        GS_IDLE   = 2'b00,
        GS_PLAY   = 2'b01,
        GS_P1_WIN = 2'b10,
        GS_P2_WIN = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        BALL_IDLE  = 2'b00,
        BALL_SERVE = 2'b01,
        BALL_MOVE  = 2'b10
    } ball_state_e;

    // Ball position plus travel direction (1 = increasing coordinate).
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dir_x;
        logic               dir_y;
    } ball_motion_t;

endpackage

// File: rtl/pong_ball_if.sv
// Scan, paddle and game-control inputs plus ball outputs of the ball generator.
interface pong_ball_if;
    import pong_pkg::*;

    logic               frame_tick;
    logic [1:0]         game_state;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] paddle1_y;
    logic [COORD_W-1:0] paddle2_y;
    logic               ball_on;
    logic [RGB_W-1:0]   rgb_ball;
    logic               score_p1;
    logic               score_p2;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;

    modport master (
        output frame_tick, game_state, x, y, paddle1_y, paddle2_y,
        input  ball_on, rgb_ball, score_p1, score_p2, ball_x, ball_y
    );

    modport slave (
        input  frame_tick, game_state, x, y, paddle1_y, paddle2_y,
        output ball_on, rgb_ball, score_p1, score_p2, ball_x, ball_y
    );

endinterface

// File: rtl/pong_ball_collide.sv
// One-frame motion step: wall reflection, paddle bounce and miss detection.
module pong_ball_collide
    import pong_pkg::*;
#(
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned BALL_SPEED = 2,
    parameter int unsigned PADDLE1_X  = 20,
    parameter int unsigned PADDLE2_X  = 610,
    parameter int unsigned PADDLE_W   = 10,
    parameter int unsigned PADDLE_H   = 80
) (
    input  ball_motion_t       cur,
    input  logic [COORD_W-1:0] paddle1_y,
    input  logic [COORD_W-1:0] paddle2_y,
    output ball_motion_t       nxt_c,
    output logic               miss_left_c,
    output logic               miss_right_c
);

    localparam logic [CALC_W-1:0] SIZE_W  = CALC_W'(BALL_SIZE);
    localparam logic [CALC_W-1:0] SPEED_W = CALC_W'(BALL_SPEED);
    localparam logic [CALC_W-1:0] P1_EDGE = CALC_W'(PADDLE1_X + PADDLE_W);
    localparam logic [CALC_W-1:0] P2_EDGE = CALC_W'(PADDLE2_X);
    localparam logic [CALC_W-1:0] PH_W    = CALC_W'(PADDLE_H);
    localparam logic [CALC_W-1:0] H_W     = CALC_W'(H_ACTIVE);
    localparam logic [CALC_W-1:0] V_W     = CALC_W'(V_ACTIVE);
    localparam logic [CALC_W-1:0] Y_MAX   = CALC_W'(V_ACTIVE - BALL_SIZE);

    logic [CALC_W-1:0] bx, by, p1y, p2y;
    logic              ov1, ov2;

    assign bx  = CALC_W'(cur.x);
    assign by  = CALC_W'(cur.y);
    assign p1y = CALC_W'(paddle1_y);
    assign p2y = CALC_W'(paddle2_y);

    // Vertical overlap with each paddle, taken from the pre-update ball row.
    assign ov1 = (by + SIZE_W > p1y) && (by < p1y + PH_W);
    assign ov2 = (by + SIZE_W > p2y) && (by < p2y + PH_W);

    // Resolve both axes independently; a bounce is checked before a miss.
    always_comb begin
        nxt_c        = cur;
        miss_left_c  = 1'b0;
        miss_right_c = 1'b0;

        if (!cur.dir_y) begin
            if (by < SPEED_W) begin
                nxt_c.y     = '0;
                nxt_c.dir_y = 1'b1;
            end else begin
                nxt_c.y = COORD_W'(by - SPEED_W);
            end
        end else begin
            if (by + SPEED_W + SIZE_W >= V_W) begin
                nxt_c.y     = COORD_W'(Y_MAX);
                nxt_c.dir_y = 1'b0;
            end else begin
                nxt_c.y = COORD_W'(by + SPEED_W);
            end
        end

        if (cur.dir_x) begin
            if ((bx + SPEED_W + SIZE_W >= P2_EDGE) && (bx + SIZE_W <= P2_EDGE) && ov2) begin
                nxt_c.x     = COORD_W'(P2_EDGE - SIZE_W);
                nxt_c.dir_x = 1'b0;
            end else if (bx + SPEED_W + SIZE_W >= H_W) begin
                miss_right_c = 1'b1;
            end else begin
                nxt_c.x = COORD_W'(bx + SPEED_W);
            end
        end else begin
            if ((bx <= P1_EDGE + SPEED_W) && (bx >= P1_EDGE) && ov1) begin
                nxt_c.x     = COORD_W'(P1_EDGE);
                nxt_c.dir_x = 1'b1;
            end else if (bx < SPEED_W) begin
                miss_left_c = 1'b1;
            end else begin
                nxt_c.x = COORD_W'(bx - SPEED_W);
            end
        end
    end

endmodule

// File: rtl/pong_ball.sv
// Pong ball: serve/move FSM, frame-synchronous position registers and pixel generator.
module pong_ball
    import pong_pkg::*;
#(
    parameter int unsigned      BALL_SIZE    = 8,
    parameter int unsigned      BALL_SPEED   = 2,
    parameter int unsigned      PADDLE1_X    = 20,
    parameter int unsigned      PADDLE2_X    = 610,
    parameter int unsigned      PADDLE_W     = 10,
    parameter int unsigned      PADDLE_H     = 80,
    parameter int unsigned      SERVE_FRAMES = 60,
    parameter logic [RGB_W-1:0] BALL_COLOR   = 12'hFFF
) (
    input logic        clk,
    input logic        reset,
    pong_ball_if.slave bus
);

    localparam int unsigned        CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [COORD_W-1:0] CENTRE_X   = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] CENTRE_Y   = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [CALC_W-1:0]  SIZE_W     = CALC_W'(BALL_SIZE);

    ball_state_e      state_q, state_d;
    ball_motion_t     ball_q, ball_d;
    ball_motion_t     coll_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             score_p1_q, score_p1_d;
    logic             score_p2_q, score_p2_d;
    logic             first_q, first_d;
    logic             serve_dx_q, serve_dx_d;
    logic             serve_dy_q, serve_dy_d;
    logic             miss_left, miss_right;
    logic             playing;

    assign playing = (game_state_e'(bus.game_state) == GS_PLAY);

    pong_ball_collide #(
        .BALL_SIZE (BALL_SIZE),
        .BALL_SPEED(BALL_SPEED),
        .PADDLE1_X (PADDLE1_X),
        .PADDLE2_X (PADDLE2_X),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H)
    ) u_collide (
        .cur         (ball_q),
        .paddle1_y   (bus.paddle1_y),
        .paddle2_y   (bus.paddle2_y),
        .nxt_c       (coll_nxt),
        .miss_left_c (miss_left),
        .miss_right_c(miss_right)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BALL_IDLE;
            ball_q     <= '{x: CENTRE_X, y: CENTRE_Y, dir_x: 1'b1, dir_y: 1'b1};
            cnt_q      <= '0;
            score_p1_q <= 1'b0;
            score_p2_q <= 1'b0;
            first_q    <= 1'b1;
            serve_dx_q <= 1'b1;
            serve_dy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ball_q     <= ball_d;
            cnt_q      <= cnt_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            first_q    <= first_d;
            serve_dx_q <= serve_dx_d;
            serve_dy_q <= serve_dy_d;
        end
    end

    // Next-state logic: leaving play always parks the ball; motion only on frame_tick.
    always_comb begin
        state_d    = state_q;
        ball_d     = ball_q;
        cnt_d      = cnt_q;
        score_p1_d = 1'b0;
        score_p2_d = 1'b0;
        first_d    = first_q;
        serve_dx_d = serve_dx_q;
        serve_dy_d = serve_dy_q;

        if (!playing) begin
            state_d  = BALL_IDLE;
            ball_d.x = CENTRE_X;
            ball_d.y = CENTRE_Y;
            cnt_d    = '0;
        end else begin
            case (state_q)
                BALL_IDLE: begin
                    state_d  = BALL_SERVE;
                    ball_d.x = CENTRE_X;
                    ball_d.y = CENTRE_Y;
                    cnt_d    = '0;
                end
                BALL_SERVE: begin
                    if (bus.frame_tick) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_d      = BALL_MOVE;
                            ball_d.dir_x = serve_dx_q;
                            if (first_q) begin
                                ball_d.dir_y = serve_dy_q;
                                first_d      = 1'b0;
                            end else begin
                                ball_d.dir_y = ~serve_dy_q;
                                serve_dy_d   = ~serve_dy_q;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                BALL_MOVE: begin
                    if (bus.frame_tick) begin
                        if (miss_right || miss_left) begin
                            score_p1_d = miss_right;
                            score_p2_d = miss_left;
                            serve_dx_d = miss_left;
                            state_d    = BALL_SERVE;
                            ball_d.x   = CENTRE_X;
                            ball_d.y   = CENTRE_Y;
                            cnt_d      = '0;
                        end else begin
                            ball_d = coll_nxt;
                        end
                    end
                end
                default: begin
                    state_d = BALL_IDLE;
                end
            endcase
        end
    end

    // Pixel hit test on the live scan position, no added latency.
    assign bus.ball_on = (state_q != BALL_IDLE)
                      && (CALC_W'(bus.x) >= CALC_W'(ball_q.x))
                      && (CALC_W'(bus.x) <  CALC_W'(ball_q.x) + SIZE_W)
                      && (CALC_W'(bus.y) >= CALC_W'(ball_q.y))
                      && (CALC_W'(bus.y) <  CALC_W'(ball_q.y) + SIZE_W);

    assign bus.rgb_ball = BALL_COLOR;
    assign bus.score_p1 = score_p1_q;
    assign bus.score_p2 = score_p2_q;
    assign bus.ball_x   = ball_q.x;
    assign bus.ball_y   = ball_q.y;

endmodule

// File: tb/tb_pong_ball.sv
// Randomized bench for pong_ball against a velocity-based behavioural model.
module tb_pong_ball;

    localparam int SZ  = 8;
    localparam int SP  = 2;
    localparam int P1X = 20;
    localparam int P2X = 610;
    localparam int PW  = 10;
    localparam int PH  = 80;
    localparam int SF  = 60;
    localparam int CX  = 316;
    localparam int CY  = 236;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pong_ball_if bus();

    pong_ball dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 serving, 2 in play; velocity as signed pixels per frame.
    int m_mode, m_bx, m_by, m_vx, m_vy, m_ticks, m_serves, m_last;
    int m_p1, m_p2;
    int dut_p1_cnt = 0;
    int dut_p2_cnt = 0;
    int p1_mode = 0;
    int p2_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int exp_on(input int px, input int py);
        return (m_mode != 0 && px >= m_bx && px < m_bx + SZ && py >= m_by && py < m_by + SZ) ? 1 : 0;
    endfunction

    task automatic model_centre();
        m_bx = CX;
        m_by = CY;
        m_ticks = 0;
    endtask

    task automatic model_move(input int p1y, input int p2y);
        int ny, nvy, nx, nvx, scorer;
        bit ov1, ov2;
        ov1 = (m_by + SZ > p1y) && (m_by < p1y + PH);
        ov2 = (m_by + SZ > p2y) && (m_by < p2y + PH);
        ny = m_by + m_vy;
        nvy = m_vy;
        if (ny < 0) begin
            ny = 0; nvy = SP;
        end else if (ny + SZ >= 480) begin
            ny = 480 - SZ; nvy = -SP;
        end
        nx = m_bx + m_vx;
        nvx = m_vx;
        scorer = 0;
        if (m_vx > 0) begin
            if (nx + SZ >= P2X && m_bx + SZ <= P2X && ov2) begin
                nx = P2X - SZ; nvx = -SP;
            end else if (nx + SZ >= 640) begin
                scorer = 1;
            end
        end else begin
            if (nx <= P1X + PW && m_bx >= P1X + PW && ov1) begin
                nx = P1X + PW; nvx = SP;
            end else if (nx < 0) begin
                scorer = 2;
            end
        end
        if (scorer != 0) begin
            if (scorer == 1) m_p1 = 1; else m_p2 = 1;
            m_last = scorer;
            m_mode = 1;
            model_centre();
        end else begin
            m_bx = nx; m_by = ny; m_vx = nvx; m_vy = nvy;
        end
    endtask

    task automatic model_clock(input logic r, input logic [1:0] g, input logic t, input int p1y, input int p2y);
        m_p1 = 0;
        m_p2 = 0;
        if (!r) begin
            m_mode = 0; model_centre();
            m_vx = SP; m_vy = SP; m_serves = 0; m_last = 0;
        end else if (g != 2'b01) begin
            m_mode = 0; model_centre();
        end else if (m_mode == 0) begin
            m_mode = 1; model_centre();
        end else if (m_mode == 1) begin
            if (t) begin
                m_ticks++;
                if (m_ticks == SF) begin
                    m_mode = 2;
                    m_vx = (m_last == 1) ? -SP : SP;
                    m_vy = (m_serves % 2 == 0) ? SP : -SP;
                    m_serves++;
                end
            end
        end else if (t) begin
            model_move(p1y, p2y);
        end
    endtask

    // One clock: random scan pixel, edge, model update, compare all outputs.
    task automatic cycle();
        logic r, t;
        logic [1:0] g;
        int p1, p2;
        if ($urandom_range(0, 1) == 1) begin
            bus.x = 10'(clampi(m_bx - 2 + int'($urandom_range(0, 11)), 0, 639));
            bus.y = 10'(clampi(m_by - 2 + int'($urandom_range(0, 11)), 0, 479));
        end else begin
            bus.x = 10'($urandom_range(0, 639));
            bus.y = 10'($urandom_range(0, 479));
        end
        r = reset; g = bus.game_state; t = bus.frame_tick;
        p1 = int'(bus.paddle1_y); p2 = int'(bus.paddle2_y);
        @(posedge clk);
        model_clock(r, g, t, p1, p2);
        #1;
        dut_p1_cnt += int'(bus.score_p1);
        dut_p2_cnt += int'(bus.score_p2);
        chk("ball_x", 32'(bus.ball_x), m_bx);
        chk("ball_y", 32'(bus.ball_y), m_by);
        chk("score_p1", 32'(bus.score_p1), m_p1);
        chk("score_p2", 32'(bus.score_p2), m_p2);
        chk("ball_on", 32'(bus.ball_on), exp_on(int'(bus.x), int'(bus.y)));
    endtask

    // Paddle policy: 0 follows the ball, 1 keeps clear of it, other = random.
    function automatic logic [9:0] pick_paddle(input int mode);
        int p;
        case (mode)
            0:       p = m_by - 36 + int'($urandom_range(0, 60)) - 30;
            1:       p = (m_by < 200) ? 300 : 0;
            default: p = int'($urandom_range(0, 1023));
        endcase
        return 10'(clampi(p, 0, 1023));
    endfunction

    task automatic tick_frame();
        bus.paddle1_y = pick_paddle(p1_mode);
        bus.paddle2_y = pick_paddle(p2_mode);
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
        cycle();
    endtask

    task automatic serve_wait();
        for (int i = 0; i < SF; i++) begin
            tick_frame();
            chk("serve_hold_x", 32'(bus.ball_x), CX);
        end
    endtask

    task automatic render_scan();
        int hits;
        hits = 0;
        for (int dy = -3; dy < SZ + 3; dy++) begin
            for (int dx = -3; dx < SZ + 3; dx++) begin
                bus.x = 10'(m_bx + dx);
                bus.y = 10'(m_by + dy);
                #1;
                chk("render_on", 32'(bus.ball_on), exp_on(m_bx + dx, m_by + dy));
                hits += int'(bus.ball_on);
            end
        end
        chk("render_hits", hits, SZ * SZ);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n0, vx0, rv;
        reset = 1'b0;
        bus.game_state = 2'b00;
        bus.frame_tick = 1'b0;
        bus.x = 10'd316;
        bus.y = 10'd236;
        bus.paddle1_y = 10'd200;
        bus.paddle2_y = 10'd200;

        // Reset values and idle blanking.
        cycle();
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
        chk("rst_ball_x", 32'(bus.ball_x), CX);
        chk("rst_ball_y", 32'(bus.ball_y), CY);
        chk("rst_score_p1", 32'(bus.score_p1), 0);
        chk("rst_rgb", 32'(bus.rgb_ball), 32'h0FFF);
        bus.x = 10'd318; bus.y = 10'd238; #1;
        chk("rst_ball_on", 32'(bus.ball_on), 0);

        // First serve launches +x/+y after exactly SF ticks.
        reset = 1'b1;
        bus.game_state = 2'b01;
        cycle();
        bus.x = 10'd316; bus.y = 10'd236; #1;
        chk("serve_ball_on", 32'(bus.ball_on), 1);
        serve_wait();
        tick_frame();
        chk("launch1_x", 32'(bus.ball_x), 318);
        chk("launch1_y", 32'(bus.ball_y), 238);

        // Right paddle bounce with no score.
        vx0 = m_vx; k = 0; n0 = dut_p1_cnt;
        while (m_vx == vx0 && m_mode == 2 && k < 400) begin tick_frame(); k++; end
        chk("bounce_r_in_time", (k < 400), 1);
        chk("bounce_r_x", 32'(bus.ball_x), P2X - SZ);
        chk("bounce_r_no_score", dut_p1_cnt - n0, 0);

        // Left player misses: one p2 pulse, then serve goes +x and -y.
        p1_mode = 1; k = 0; n0 = dut_p2_cnt;
        while (m_mode == 2 && k < 600) begin tick_frame(); k++; end
        chk("miss_l_pulses", dut_p2_cnt - n0, 1);
        chk("miss_l_centre_x", 32'(bus.ball_x), CX);
        p1_mode = 0;
        serve_wait();
        tick_frame();
        chk("launch2_x", 32'(bus.ball_x), 318);
        chk("launch2_y", 32'(bus.ball_y), 234);

        // Right player misses: one p1 pulse, then serve goes -x and +y.
        p2_mode = 1; k = 0; n0 = dut_p1_cnt;
        while (m_mode == 2 && k < 600) begin tick_frame(); k++; end
        chk("miss_r_pulses", dut_p1_cnt - n0, 1);
        chk("miss_r_centre_y", 32'(bus.ball_y), CY);
        p2_mode = 0;
        serve_wait();
        tick_frame();
        chk("launch3_x", 32'(bus.ball_x), 314);
        chk("launch3_y", 32'(bus.ball_y), 238);

        // Render window, then leave play mid-rally.
        for (int i = 0; i < 5; i++) tick_frame();
        render_scan();
        bus.game_state = 2'b00;
        cycle();
        chk("abort_x", 32'(bus.ball_x), CX);
        chk("abort_y", 32'(bus.ball_y), CY);
        for (int i = 0; i < 16; i++) begin
            bus.frame_tick = 1'(i % 2);
            cycle();
            chk("abort_ball_on", 32'(bus.ball_on), 0);
        end
        bus.frame_tick = 1'b0;

        // Reset pulse mid-rally, with a frame tick present.
        bus.game_state = 2'b01;
        cycle();
        serve_wait();
        for (int i = 0; i < 8; i++) tick_frame();
        n0 = dut_p1_cnt + dut_p2_cnt;
        reset = 1'b0;
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
        reset = 1'b1;
        chk("rstmid_x", 32'(bus.ball_x), CX);
        chk("rstmid_y", 32'(bus.ball_y), CY);
        chk("rstmid_no_score", dut_p1_cnt + dut_p2_cnt - n0, 0);

        // Free-running random play with occasional aborts and resets.
        for (int i = 0; i < 14000; i++) begin
            rv = int'($urandom_range(0, 3999));
            reset = (rv == 0) ? 1'b0 : 1'b1;
            bus.game_state = (rv == 1 || rv == 2) ? 2'($urandom_range(2, 4)) : 2'b01;
            bus.frame_tick = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            if (bus.frame_tick) begin
                bus.paddle1_y = pick_paddle(($urandom_range(0, 3) == 0) ? 2 : 0);
                bus.paddle2_y = pick_paddle(($urandom_range(0, 3) == 0) ? 2 : 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
